// File: rtl/updown_count_scheduler.sv
// -----------------------------------------------------------------------------
// updown_count_scheduler
//
// Purpose:
//   Owns one shared WIDTH-bit up/down count register and time-shares it
//   between two requesters. A round-robin arbiter picks a winner. The FSM then
//   applies the winner's run of N steps (+1 or -1), one step per clock.
//
// Optional feature:
//   Macro UPDOWN_COUNT_SCHED_SAT_EN
//     defined   : counting clamps at 0 and 2^WIDTH-1 instead of wrapping.
//                 sat is set on the first clamped step and is cleared when the
//                 next run is granted.
//     undefined : counting wraps modulo 2^WIDTH and sat is tied to 0.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous reset, active low
//   req      in   2        per-requester run request, held until its done pulse
//   req_dir  in   2        per-requester direction (1 = up, 0 = down)
//   req_len  in   2*WIDTH  per-requester step count, slice i*WIDTH +: WIDTH
//   gnt      out  2        one-hot grant, high in GRANT, RUN and DONE
//   done     out  2        one-cycle pulse to the served requester
//   busy     out  1        high whenever the FSM is not idle
//   out      out  WIDTH    shared count value
//   sat      out  1        saturation-hit flag
// -----------------------------------------------------------------------------
module updown_count_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_dir,
    input  logic [2*WIDTH-1:0] req_len,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic               busy,
    output logic [WIDTH-1:0]   out,
    output logic               sat
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_w;      // requester being served
    logic             r_dir;    // latched direction of the current run
    logic             r_rr;     // requester that wins when both ask
    logic [WIDTH-1:0] r_rem;    // steps still to apply
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_busy;

    logic             w_win;
    logic [WIDTH-1:0] w_len;
    logic [1:0]       w_sel;

    // A lone requester always wins. Under contention, the round-robin pointer wins.
    assign w_win = (req == 2'b11) ? r_rr : req[1];
    assign w_len = w_win ? req_len[2*WIDTH-1:WIDTH] : req_len[WIDTH-1:0];
    assign w_sel = r_w ? 2'b10 : 2'b01;

    // One step of the shared count. With saturation enabled, a step past
    // either end holds the value.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v,
                                                input logic up);
`ifdef UPDOWN_COUNT_SCHED_SAT_EN
        if (f_clamp(v, up)) return v;
`endif
        return up ? (v + ONE) : (v - ONE);
    endfunction

`ifdef UPDOWN_COUNT_SCHED_SAT_EN
    function automatic logic f_clamp(input logic [WIDTH-1:0] v, input logic up);
        return (up && (&v)) || (!up && ~(|v));
    endfunction

    logic r_sat;
    assign sat = r_sat;
`else
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_rr    <= 1'b0;
`ifdef UPDOWN_COUNT_SCHED_SAT_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_w     <= w_win;
                        r_dir   <= req_dir[w_win];
                        r_rem   <= w_len;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
`ifdef UPDOWN_COUNT_SCHED_SAT_EN
                        r_sat   <= 1'b0;
`endif
                    end
                end
                S_GRANT: begin
                    // A zero-length run skips RUN entirely and leaves the count untouched.
                    if (r_rem == '0) begin
                        r_done  <= w_sel;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_out <= f_step(r_out, r_dir);
`ifdef UPDOWN_COUNT_SCHED_SAT_EN
                    if (f_clamp(r_out, r_dir)) r_sat <= 1'b1;
`endif
                    r_rem <= r_rem - ONE;
                    if (r_rem == ONE) begin
                        r_done  <= w_sel;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_rr    <= ~r_w;   // favour the requester not just served
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign out  = r_out;

endmodule
